// File: rtl/loop_program_sequencer.sv
// loop_program_sequencer
//   Front end for the loop controller. It accepts a loop program as a
//   valid/ready stream, with one max-iteration count per beat and a flag on
//   the last beat. Each accepted entry is written into the controller's loop
//   buffer, and then start is pulsed. The block counts run cycles and issued
//   ops until the controller reports done, then returns a completion record
//   over a valid/ready response port.
//
//   Ports
//     clk, reset              clock; asynchronous active-high reset
//     cfg_valid/ready         program beat handshake
//     cfg_max_iter, cfg_last  beat payload and end-of-program flag
//     ctrl_loop_wr_v/_max_iter  loop-buffer write strobe and data (registered)
//     ctrl_start              one-cycle start pulse to the controller
//     ctrl_done               controller finished (only honoured in RUN)
//     ctrl_offset_valid       controller issued an op this cycle
//     cmp_valid/ready         completion record handshake
//     cmp_cycles/ops/error    completion record, forced to 0 when not valid
//     busy                    sequencer not idle
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for first program beat
//   LOAD  | accepting beats, writing loop buffer
//   DRAIN | program overflowed; swallowing beats up to the last one
//   START | first cycle: last write strobe out; second cycle: start pulse
//   RUN   | controller running; counting cycles and ops
//   RESP  | completion record presented until consumed
module loop_program_sequencer #(
   parameter int LOOP_COUNT_W = 8,
   parameter int INST_ADDR_W  = 4,
   parameter int CNT_W        = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [LOOP_COUNT_W-1:0] cfg_max_iter,
   input  logic                    cfg_last,
   output logic                    ctrl_loop_wr_v,
   output logic [LOOP_COUNT_W-1:0] ctrl_loop_wr_max_iter,
   output logic                    ctrl_start,
   input  logic                    ctrl_done,
   input  logic                    ctrl_offset_valid,
   output logic                    cmp_valid,
   input  logic                    cmp_ready,
   output logic [CNT_W-1:0]        cmp_cycles,
   output logic [CNT_W-1:0]        cmp_ops,
   output logic                    cmp_error,
   output logic                    busy
);

   localparam int MAX_LOOPS = 2 ** INST_ADDR_W;
   localparam int N_W       = INST_ADDR_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_START, S_RUN, S_RESP} state_t;

   state_t           state, state_nxt;
   logic [N_W-1:0]   n;
   logic             err;
   logic [CNT_W-1:0] cyc;
   logic [CNT_W-1:0] ops;
   logic             start_arm;
   logic             accept;
   logic             overflow_beat;
   logic             loading;
   logic             write_beat;

   assign accept        = cfg_valid && cfg_ready;
   assign overflow_beat = (n == N_W'(MAX_LOOPS));
   assign loading       = (state == S_IDLE) || (state == S_LOAD);
   assign write_beat    = accept && loading && !overflow_beat;

   always_comb begin
      state_nxt  = state;
      cfg_ready  = 1'b0;
      ctrl_start = 1'b0;
      cmp_valid  = 1'b0;
      case (state)
         S_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_nxt = cfg_last ? S_START : S_LOAD;
         end
         S_LOAD: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               if (overflow_beat)  state_nxt = cfg_last ? S_RESP : S_DRAIN;
               else if (cfg_last)  state_nxt = S_START;
            end
         end
         S_DRAIN: begin
            cfg_ready = 1'b1;
            if (cfg_valid && cfg_last) state_nxt = S_RESP;
         end
         S_START: begin
            // start waits one cycle so it follows the final write strobe
            ctrl_start = start_arm;
            if (start_arm) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (ctrl_done) state_nxt = S_RESP;
         end
         S_RESP: begin
            cmp_valid = 1'b1;
            if (cmp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                 <= S_IDLE;
         n                     <= '0;
         err                   <= 1'b0;
         cyc                   <= '0;
         ops                   <= '0;
         start_arm             <= 1'b0;
         ctrl_loop_wr_v        <= 1'b0;
         ctrl_loop_wr_max_iter <= '0;
      end else begin
         state          <= state_nxt;
         start_arm      <= (state == S_START) && !start_arm;
         ctrl_loop_wr_v <= write_beat;
         if (write_beat) begin
            ctrl_loop_wr_max_iter <= cfg_max_iter;
            n                     <= n + N_W'(1);
         end
         if (accept && loading && overflow_beat) err <= 1'b1;
         if (state == S_RUN) begin
            if (cyc != '1)                      cyc <= cyc + CNT_W'(1);
            if (ctrl_offset_valid && ops != '1) ops <= ops + CNT_W'(1);
         end
         if (state == S_RESP && cmp_ready) begin
            n   <= '0;
            err <= 1'b0;
            cyc <= '0;
            ops <= '0;
         end
      end
   end

   assign cmp_cycles = cmp_valid ? cyc : '0;
   assign cmp_ops    = cmp_valid ? ops : '0;
   assign cmp_error  = cmp_valid && err;
   assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_loop_program_sequencer.sv
module tb_loop_program_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_max_iter = '0;
   logic       cfg_last = 1'b0;
   logic       ctrl_done = 1'b0;
   logic       ctrl_offset_valid = 1'b0;
   logic       cmp_ready = 1'b0;

   logic        cfg_ready, wr_v, start, cmp_valid, cmp_error, busy;
   logic [7:0]  wr_data;
   logic [31:0] cmp_cycles, cmp_ops;

   logic        s_cfg_ready, s_wr_v, s_start, s_cmp_valid, s_cmp_error, s_busy;
   logic [7:0]  s_wr_data;
   logic [3:0]  s_cmp_cycles, s_cmp_ops;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int wr_cnt = 0;
   int s0, w0;

   always #5 clk = ~clk;

   loop_program_sequencer dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_max_iter(cfg_max_iter), .cfg_last(cfg_last),
      .ctrl_loop_wr_v(wr_v), .ctrl_loop_wr_max_iter(wr_data),
      .ctrl_start(start), .ctrl_done(ctrl_done),
      .ctrl_offset_valid(ctrl_offset_valid),
      .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
      .cmp_cycles(cmp_cycles), .cmp_ops(cmp_ops),
      .cmp_error(cmp_error), .busy(busy)
   );

   loop_program_sequencer #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
      .cfg_max_iter(cfg_max_iter), .cfg_last(cfg_last),
      .ctrl_loop_wr_v(s_wr_v), .ctrl_loop_wr_max_iter(s_wr_data),
      .ctrl_start(s_start), .ctrl_done(ctrl_done),
      .ctrl_offset_valid(ctrl_offset_valid),
      .cmp_valid(s_cmp_valid), .cmp_ready(cmp_ready),
      .cmp_cycles(s_cmp_cycles), .cmp_ops(s_cmp_ops),
      .cmp_error(s_cmp_error), .busy(s_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one cycle; observe just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (start) start_cnt++;
      if (wr_v)  wr_cnt++;
   endtask

   task automatic single_to_run(input logic [7:0] v);
      cfg_valid = 1'b1; cfg_max_iter = v; cfg_last = 1'b1;
      tick();
      cfg_valid = 1'b0; cfg_last = 1'b0;
      tick();
      tick();
   endtask

   task automatic respond();
      cmp_ready = 1'b1;
      tick();
      cmp_ready = 1'b0;
   endtask

   task automatic overflow_run(input int nb);
      s0 = start_cnt;
      w0 = wr_cnt;
      for (int i = 0; i < nb; i++) begin
         cfg_valid = 1'b1; cfg_max_iter = 8'(i + 1); cfg_last = (i == nb - 1);
         chk("ov_cfg_ready", cfg_ready, 1'b1);
         tick();
         chk("ov_strobe", wr_v, (i < 16));
         if (i < 16) chk("ov_data", wr_data, 8'(i + 1));
      end
      cfg_valid = 1'b0; cfg_last = 1'b0;
      chk("ov_cmp_valid", cmp_valid, 1'b1);
      chk("ov_cmp_error", cmp_error, 1'b1);
      chk("ov_cmp_cycles", cmp_cycles, 32'd0);
      chk("ov_cmp_ops", cmp_ops, 32'd0);
      chk("ov_cfg_ready_resp", cfg_ready, 1'b0);
      chk("ov_strobe_count", wr_cnt - w0, 16);
      chk("ov_no_start", start_cnt - s0, 0);
      respond();
      chk("ov_cleared_error", cmp_error, 1'b0);
      chk("ov_idle", busy, 1'b0);
   endtask

   initial begin
      // reset values
      tick();
      tick();
      chk("rst_cfg_ready", cfg_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr_v", wr_v, 1'b0);
      chk("rst_start", start, 1'b0);
      chk("rst_cmp_valid", cmp_valid, 1'b0);
      chk("rst_cmp_cycles", cmp_cycles, 32'd0);
      reset = 1'b0;
      tick();

      // three-beat program [2,1,3]
      cfg_valid = 1'b1; cfg_max_iter = 8'd2; cfg_last = 1'b0;
      tick();
      chk("p3_wr0_v", wr_v, 1'b1);
      chk("p3_wr0_d", wr_data, 8'd2);
      chk("p3_busy", busy, 1'b1);
      chk("p3_ready_load", cfg_ready, 1'b1);
      cfg_max_iter = 8'd1;
      tick();
      chk("p3_wr1_v", wr_v, 1'b1);
      chk("p3_wr1_d", wr_data, 8'd1);
      cfg_max_iter = 8'd3; cfg_last = 1'b1;
      tick();
      chk("p3_wr2_v", wr_v, 1'b1);
      chk("p3_wr2_d", wr_data, 8'd3);
      chk("p3_start_early", start, 1'b0);
      chk("p3_ready_low", cfg_ready, 1'b0);
      cfg_valid = 1'b0; cfg_last = 1'b0;
      tick();
      chk("p3_start", start, 1'b1);
      chk("p3_wr_after", wr_v, 1'b0);
      tick();
      chk("p3_start_once", start, 1'b0);
      chk("p3_strobes", wr_cnt, 3);
      for (int i = 0; i < 10; i++) begin
         ctrl_offset_valid = (i < 7);
         ctrl_done = (i == 9);
         tick();
      end
      ctrl_done = 1'b0; ctrl_offset_valid = 1'b0;
      chk("p3_cmp_valid", cmp_valid, 1'b1);
      chk("p3_cycles", cmp_cycles, 32'd10);
      chk("p3_ops", cmp_ops, 32'd7);
      chk("p3_error", cmp_error, 1'b0);
      chk("p3_sat_cycles", s_cmp_cycles, 4'd10);
      chk("p3_sat_ops", s_cmp_ops, 4'd7);

      // response back-pressure with a beat waiting
      cfg_valid = 1'b1; cfg_max_iter = 8'd9; cfg_last = 1'b1;
      w0 = wr_cnt;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", cmp_valid, 1'b1);
         chk("hold_cycles", cmp_cycles, 32'd10);
         chk("hold_ops", cmp_ops, 32'd7);
         chk("hold_cfg_ready", cfg_ready, 1'b0);
      end
      cfg_valid = 1'b0; cfg_last = 1'b0;
      respond();
      chk("hs_cmp_valid", cmp_valid, 1'b0);
      chk("hs_cmp_cycles", cmp_cycles, 32'd0);
      chk("hs_cmp_ops", cmp_ops, 32'd0);
      chk("hs_cfg_ready", cfg_ready, 1'b1);
      chk("hs_idle", busy, 1'b0);
      chk("hold_no_strobe", wr_cnt - w0, 0);

      // done outside RUN is ignored
      ctrl_done = 1'b1;
      tick();
      ctrl_done = 1'b0;
      chk("done_idle_ignored", busy, 1'b0);
      tick();
      chk("done_idle_no_resp", cmp_valid, 1'b0);

      // single-beat program
      s0 = start_cnt;
      cfg_valid = 1'b1; cfg_max_iter = 8'd5; cfg_last = 1'b1;
      tick();
      chk("s1_wr_v", wr_v, 1'b1);
      chk("s1_wr_d", wr_data, 8'd5);
      chk("s1_start_early", start, 1'b0);
      chk("s1_ready_low", cfg_ready, 1'b0);
      cfg_valid = 1'b0; cfg_last = 1'b0;
      tick();
      chk("s1_start", start, 1'b1);
      tick();
      chk("s1_run_busy", busy, 1'b1);
      chk("s1_start_once", start_cnt - s0, 1);
      ctrl_done = 1'b1;
      tick();
      ctrl_done = 1'b0;
      chk("s1_cycles", cmp_cycles, 32'd1);
      chk("s1_ops", cmp_ops, 32'd0);
      respond();

      // overflow: 17th beat is last; then 19 beats with drain
      overflow_run(17);
      overflow_run(19);

      // saturation on the narrow-counter instance
      single_to_run(8'd1);
      for (int i = 0; i < 20; i++) begin
         ctrl_offset_valid = 1'b1;
         ctrl_done = (i == 19);
         tick();
      end
      ctrl_done = 1'b0; ctrl_offset_valid = 1'b0;
      chk("sat_wide_cycles", cmp_cycles, 32'd20);
      chk("sat_wide_ops", cmp_ops, 32'd20);
      chk("sat_cycles", s_cmp_cycles, 4'd15);
      chk("sat_ops", s_cmp_ops, 4'd15);
      respond();

      // reset asserted during RUN
      single_to_run(8'd4);
      ctrl_offset_valid = 1'b1;
      tick();
      tick();
      chk("rr_running", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rr_busy", busy, 1'b0);
      chk("rr_cfg_ready", cfg_ready, 1'b1);
      chk("rr_cmp_valid", cmp_valid, 1'b0);
      chk("rr_start", start, 1'b0);
      chk("rr_wr_v", wr_v, 1'b0);
      ctrl_offset_valid = 1'b0;
      tick();
      reset = 1'b0;
      s0 = start_cnt;
      w0 = wr_cnt;
      repeat (4) tick();
      chk("rr_no_start", start_cnt - s0, 0);
      chk("rr_no_strobe", wr_cnt - w0, 0);
      chk("rr_idle", busy, 1'b0);

      // normal program after reset
      single_to_run(8'd7);
      chk("pr_strobe", wr_cnt - w0, 1);
      chk("pr_start", start_cnt - s0, 1);
      for (int i = 0; i < 3; i++) begin
         ctrl_offset_valid = (i != 1);
         ctrl_done = (i == 2);
         tick();
      end
      ctrl_done = 1'b0; ctrl_offset_valid = 1'b0;
      chk("pr_cycles", cmp_cycles, 32'd3);
      chk("pr_ops", cmp_ops, 32'd2);
      chk("pr_error", cmp_error, 1'b0);
      respond();
      chk("pr_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
